// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths and FSM state encoding for the register-file arbiter
package regfile_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;
    localparam int REG_SEL_W = 3;
    localparam int DATA_W = 16;
    localparam int MAX_REQ = 8;
    localparam int PTR_W = $clog2(MAX_REQ);
endpackage

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester bus plus register-file port bundle
interface regfile_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] Req, We, Ack;
    logic [REG_SEL_W*N_REQ-1:0] Addr_A, Addr_B;
    logic [DATA_W*N_REQ-1:0] Wdata;
    logic [DATA_W-1:0] Rdata_A, Rdata_B, RF_D, RF_SR1_OUT, RF_SR2_OUT;
    logic [REG_SEL_W-1:0] RF_DR, RF_SR1, RF_SR2;
    logic Busy, RF_LD;
    modport master (
        output Req, We, Addr_A, Addr_B, Wdata, RF_SR1_OUT, RF_SR2_OUT,
        input Ack, Rdata_A, Rdata_B, Busy, RF_D, RF_DR, RF_SR1, RF_SR2, RF_LD
    );
    modport slave (
        input Req, We, Addr_A, Addr_B, Wdata, RF_SR1_OUT, RF_SR2_OUT,
        output Ack, Rdata_A, Rdata_B, Busy, RF_D, RF_DR, RF_SR1, RF_SR2, RF_LD
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at pointer
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] pointer,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);
    // Walk backwards so the candidate closest to pointer is assigned last and wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(pointer) + i) % N_REQ]) begin
                grant_valid = 1'b1;
                grant_idx = PTR_W'((int'(pointer) + i) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: serialises N_REQ requesters onto one register file,
// IDLE -> ACCESS -> ACK with round-robin grant order.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input logic Clk,
    input logic Reset_n,
    regfile_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_ACK = ACK;
    logic [1:0] state;
    logic [PTR_W-1:0] ptr, win, grant_idx;
    logic grant_valid, lat_we;
    logic [REG_SEL_W-1:0] lat_a, lat_b;
    logic [DATA_W-1:0] lat_d, rd_a, rd_b;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req(bus.Req),
        .pointer(ptr),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            ptr <= '0;
            win <= '0;
            lat_we <= 1'b0;
            lat_a <= '0;
            lat_b <= '0;
            lat_d <= '0;
            rd_a <= '0;
            rd_b <= '0;
        end else if (state == S_IDLE && grant_valid) begin
            state <= S_ACCESS;
            win <= grant_idx;
            ptr <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            lat_we <= bus.We[grant_idx];
            lat_a <= bus.Addr_A[grant_idx*REG_SEL_W +: REG_SEL_W];
            lat_b <= bus.Addr_B[grant_idx*REG_SEL_W +: REG_SEL_W];
            lat_d <= bus.Wdata[grant_idx*DATA_W +: DATA_W];
        end else if (state == S_ACCESS) begin
            state <= S_ACK;
            rd_a <= lat_we ? rd_a : bus.RF_SR1_OUT;
            rd_b <= lat_we ? rd_b : bus.RF_SR2_OUT;
        end else begin
            state <= S_IDLE;
        end
    end

    assign bus.Ack = (state == S_ACK) ? (N_REQ'(1) << win) : '0;
    assign bus.Busy = state != S_IDLE;
    assign bus.RF_LD = (state == S_ACCESS) && lat_we;
    assign bus.RF_DR = lat_a;
    assign bus.RF_SR1 = lat_a;
    assign bus.RF_SR2 = lat_b;
    assign bus.RF_D = lat_d;
    assign bus.Rdata_A = rd_a;
    assign bus.Rdata_B = rd_b;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: scoreboard bench for two- and four-requester arbiters
module tb_regfile_arbiter;
    typedef struct {
        int idx;
        logic [15:0] ra, rb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0, n_bad = 0, cyc = 0, ld_cnt = 0;
    logic [2:0] last_dr = '0;
    logic [15:0] exp_ra = '0, exp_rb = '0;
    logic [15:0] rf [8] = '{default: 16'h0};
    exp_t sb[$];
    exp_t m2;
    int q4[$];
    int m4;

    regfile_arbiter_if #(.N_REQ(2)) b2 ();
    regfile_arbiter_if #(.N_REQ(4)) b4 ();

    regfile_arbiter #(.N_REQ(2)) dut2 (.Clk(clk), .Reset_n(rst_n), .bus(b2));
    regfile_arbiter #(.N_REQ(4)) dut4 (.Clk(clk), .Reset_n(rst_n), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) if (b2.RF_LD) rf[b2.RF_DR] <= b2.RF_D;
    assign b2.RF_SR1_OUT = rf[b2.RF_SR1];
    assign b2.RF_SR2_OUT = rf[b2.RF_SR2];
    assign b4.RF_SR1_OUT = 16'h0;
    assign b4.RF_SR2_OUT = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (b2.RF_LD) begin
            ld_cnt++;
            last_dr = b2.RF_DR;
        end
        if (b2.Ack !== 2'b00) begin
            if (sb.size() == 0) check("unexpected_ack2", 32'(b2.Ack), 0);
            else begin
                m2 = sb.pop_front();
                check("ack2_idx", 32'(b2.Ack), 32'(1) << m2.idx);
                check("rdata_a", 32'(b2.Rdata_A), 32'(m2.ra));
                check("rdata_b", 32'(b2.Rdata_B), 32'(m2.rb));
            end
        end
        if (b4.Ack !== 4'b0000) begin
            if (q4.size() == 0) check("unexpected_ack4", 32'(b4.Ack), 0);
            else begin
                m4 = q4.pop_front();
                check("ack4_idx", 32'(b4.Ack), 32'(1) << m4);
            end
        end
    end

    task automatic issue(input int idx, input bit we, input logic [2:0] a, input logic [2:0] b,
                         input logic [15:0] d, input logic [15:0] ea, input logic [15:0] eb);
        int k, ld0;
        if (!we) begin
            exp_ra = ea;
            exp_rb = eb;
        end
        sb.push_back(exp_t'{idx, exp_ra, exp_rb});
        b2.We[idx] = we;
        b2.Addr_A[idx*3 +: 3] = a;
        b2.Addr_B[idx*3 +: 3] = b;
        b2.Wdata[idx*16 +: 16] = d;
        b2.Req[idx] = 1'b1;
        ld0 = ld_cnt;
        k = 0;
        while (!b2.Ack[idx] && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("ack_latency", k, 2);
        check("ld_cycles", ld_cnt - ld0, 32'(we));
        if (we) begin
            check("ld_dest", 32'(last_dr), 32'(a));
            check("rf_store", 32'(rf[a]), 32'(d));
        end
        b2.Req[idx] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] r);
        b4.Req = r;
        for (int k = 0; k < 30 && b4.Req != 4'b0; k++) begin
            @(negedge clk);
            if (|b4.Ack) b4.Req = b4.Req & ~b4.Ack;
        end
        check("n4_drained", 32'(b4.Req), 0);
        @(negedge clk);
    endtask

    initial begin
        int n, prev;
        b2.Req = '0; b2.We = '0; b2.Addr_A = '0; b2.Addr_B = '0; b2.Wdata = '0;
        b4.Req = '0; b4.We = '0; b4.Addr_A = '0; b4.Addr_B = '0; b4.Wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(b2.Ack), 0);
        check("rst_busy", 32'(b2.Busy), 0);
        check("rst_ld", 32'(b2.RF_LD), 0);
        check("rst_rdata_a", 32'(b2.Rdata_A), 0);
        check("rst_rdata_b", 32'(b2.Rdata_B), 0);
        check("rst_dr", 32'(b2.RF_DR), 0);
        check("rst_d", 32'(b2.RF_D), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 1'b1, 3'd3, 3'd0, 16'hBEEF, 0, 0);
        issue(0, 1'b1, 3'd2, 3'd0, 16'h1234, 0, 0);
        issue(1, 1'b1, 3'd5, 3'd0, 16'h00FF, 0, 0);
        issue(1, 1'b0, 3'd2, 3'd5, 16'h0, 16'h1234, 16'h00FF);
        issue(0, 1'b1, 3'd7, 3'd0, 16'hA5A5, 0, 0);
        issue(1, 1'b0, 3'd7, 3'd3, 16'h0, 16'hA5A5, 16'hBEEF);

        // Both requesters hold Req straight out of reset
        rst_n = 1'b0;
        b2.We = 2'b00;
        b2.Addr_A = {3'd3, 3'd2};
        b2.Addr_B = {3'd7, 3'd5};
        b2.Req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{0, 16'h1234, 16'h00FF});
            sb.push_back(exp_t'{1, 16'hBEEF, 16'hA5A5});
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        prev = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (|b2.Ack) begin
                if (n > 0) check("ack_gap", cyc - prev, 3);
                prev = cyc;
                n++;
            end
        end
        check("contention_acks", n, 4);
        b2.Req = 2'b00;
        @(negedge clk);

        b2.We[0] = 1'b1;
        b2.Addr_A[2:0] = 3'd4;
        b2.Wdata[15:0] = 16'h5555;
        b2.Req[0] = 1'b1;
        @(posedge clk);
        #1;
        check("abort_pre_ld", 32'(b2.RF_LD), 1);
        rst_n = 1'b0;
        #1;
        check("abort_ld", 32'(b2.RF_LD), 0);
        check("abort_busy", 32'(b2.Busy), 0);
        check("abort_ack", 32'(b2.Ack), 0);
        check("abort_dr", 32'(b2.RF_DR), 0);
        b2.Req = 2'b00;
        repeat (2) @(negedge clk);
        check("abort_r4", 32'(rf[4]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        q4.push_back(1);
        run4(4'b0010);
        q4.push_back(3);
        q4.push_back(1);
        run4(4'b1010);

        repeat (3) @(negedge clk);
        check("sb2_empty", sb.size(), 0);
        check("sb4_empty", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
